mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/arb_pick.sv | 36 +++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the two-port memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE / BUSY / RESP)
//   req_id_t    : requester identity (REQ_I = instruction side, REQ_D = data side)
//   other_side  : helper returning the opposite requester
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    function automatic req_id_t other_side(input req_id_t id);
        return (id == REQ_I) ? REQ_D : REQ_I;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner selection between the I and D requesters.
//   i_req, d_req : qualified request levels
//   last_grant   : side granted most recently (only consulted on a tie)
//   grant_c      : selected requester (don't-care when neither requests)
// Build option: ARB_ROUND_ROBIN_EN -> a tie goes to the side not granted last;
// otherwise a tie always goes to D.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic    i_req,
    input  logic    d_req,
    input  req_id_t last_grant,
    output req_id_t grant_c
);

    // Single requester always wins; ties resolved by build option.
    always_comb begin
        grant_c = REQ_D;
        if (i_req && !d_req) begin
            grant_c = REQ_I;
        end else if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_c = other_side(last_grant);
`else
            grant_c = REQ_D;
`endif
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority never looks at the grant history.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an I-side read port and a D-side read/write port
// onto one memory block port, one transaction at a time.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   i_req, i_addr                 : I-side block read request (held until i_ready)
//   i_rdata, i_ready              : I-side returned block and completion pulse
//   d_req, d_we, d_addr, d_wdata  : D-side block request (held until d_ready)
//   d_rdata, d_ready              : D-side returned block and completion pulse
//   mem_read, mem_write           : memory strobes (combinational, low in the mem_ready cycle)
//   mem_addr, mem_wdata           : latched address / write block to memory
//   mem_rdata, mem_ready          : memory returns
//   busy                          : high whenever the arbiter is not IDLE
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie breaking (else D wins ties).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned BLK_W  = 128
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [BLK_W-1:0]  i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [BLK_W-1:0]  d_wdata,
    output logic [BLK_W-1:0]  d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BLK_W-1:0]  mem_wdata,
    input  logic [BLK_W-1:0]  mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    req_id_t           id_q;
    req_id_t           pick_c;
    req_id_t           last_grant_c;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BLK_W-1:0]  wdata_q;
    logic              grant_c;
    logic              done_c;

`ifdef ARB_ROUND_ROBIN_EN
    req_id_t last_grant_q;
    assign last_grant_c = last_grant_q;
`else
    assign last_grant_c = REQ_I;
`endif

    arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant_c),
        .grant_c    (pick_c)
    );

    // The completion pulse shows in the first IDLE cycle while the finished
    // requester may still hold its request; skip sampling in that cycle so the
    // same request is not served twice.
    assign grant_c = (state_q == IDLE) && !(i_ready || d_ready) && (i_req || d_req);
    assign done_c  = (state_q == BUSY) && mem_ready;

    // Strobes drop in the mem_ready cycle so the memory never restarts.
    assign mem_read  = (state_q == BUSY) && !we_q && !mem_ready;
    assign mem_write = (state_q == BUSY) &&  we_q && !mem_ready;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_c) state_d = BUSY;
            BUSY:    if (mem_ready) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Winner's request latched at grant; stable for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q    <= REQ_I;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_c) begin
            id_q    <= pick_c;
            we_q    <= (pick_c == REQ_D) && d_we;
            addr_q  <= (pick_c == REQ_D) ? d_addr : i_addr;
            wdata_q <= (pick_c == REQ_D) ? d_wdata : '0;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Grant history for tie breaking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= REQ_I;
        end else if (grant_c) begin
            last_grant_q <= pick_c;
        end
    end
`endif

    // Registered status, completion pulses and read-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            busy    <= (state_d != IDLE);
            i_ready <= (state_q == RESP) && (id_q == REQ_I);
            d_ready <= (state_q == RESP) && (id_q == REQ_D);
            if (done_c && !we_q) begin
                if (id_q == REQ_I) begin
                    i_rdata <= mem_rdata;
                end else begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter with a
// transaction-level reference model (grant rule, timing from latency, memory
// contents) and a behavioural memory responder.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BLK_W  = 128;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [BLK_W-1:0]  i_rdata;
    logic              i_ready;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [BLK_W-1:0]  d_wdata;
    logic [BLK_W-1:0]  d_rdata;
    logic              d_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [BLK_W-1:0]  mem_wdata;
    logic [BLK_W-1:0]  mem_rdata;
    logic              mem_ready;
    logic              busy;

    mem_arbiter #(.ADDR_W(ADDR_W), .BLK_W(BLK_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: one transaction in flight at most.
    bit               act;
    int               g_cyc;
    int               m_lat;
    bit               m_d;
    bit               m_we;
    logic [31:0]      m_addr;
    logic [BLK_W-1:0] m_wdata;
    bit               lg_d;
    int               free_cyc;
    logic [BLK_W-1:0] exp_i_rd;
    logic [BLK_W-1:0] exp_d_rd;
    logic [BLK_W-1:0] ref_mem [logic [31:0]];

    // Requester agents.
    bit               i_wait, d_wait, i_done, d_done;
    bit               dir_i, dir_d, dir_d_we;
    logic [31:0]      dir_i_addr, dir_d_addr;
    logic [BLK_W-1:0] dir_d_data;
    int               p_req, p_drop, p_spur, lat_min, lat_max;

    // Memory responder.
    logic [BLK_W-1:0] ram [logic [31:0]];
    bit               mr_pend, mr_we, prev_strobe;
    int               mr_at, edges, next_lat;
    logic [31:0]      mr_addr;
    logic [BLK_W-1:0] mr_wdata;

    bit order_q [$];

    task automatic chk(input string tag, input logic [BLK_W-1:0] got, input logic [BLK_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [BLK_W-1:0] line_init(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, 32'hC0DE_0000 | {16'h0, a[15:0]}};
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h0001_0000 + (32'($urandom_range(7, 0)) << 4);
    endfunction

    function automatic logic [BLK_W-1:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Inputs for the current cycle, applied just after the rising edge.
    task automatic drive();
        mem_ready = 1'b0;
        mem_rdata = rand_blk();
        if (mr_pend && cyc == mr_at) begin
            mem_ready = 1'b1;
            if (mr_we) ram[mr_addr] = mr_wdata;
            else mem_rdata = ram.exists(mr_addr) ? ram[mr_addr] : line_init(mr_addr);
            mr_pend = 1'b0;
        end else if (!mr_pend && !(act && cyc > g_cyc && cyc <= g_cyc + m_lat + 1)
                     && $urandom_range(99, 0) < p_spur) begin
            mem_ready = 1'b1;
        end

        if (i_wait && i_done) begin
            i_wait = 0; i_done = 0; i_req = 1'b0;
        end else if (i_wait && i_req && act && !m_d && cyc > g_cyc && $urandom_range(99, 0) < p_drop) begin
            i_req = 1'b0;
        end
        if (!i_wait && (dir_i || $urandom_range(99, 0) < p_req)) begin
            i_req  = 1'b1;
            i_addr = dir_i ? dir_i_addr : rand_addr();
            i_wait = 1; dir_i = 0;
        end

        if (d_wait && d_done) begin
            d_wait = 0; d_done = 0; d_req = 1'b0;
        end else if (d_wait && d_req && act && m_d && cyc > g_cyc && $urandom_range(99, 0) < p_drop) begin
            d_req = 1'b0;
        end
        if (!d_wait && (dir_d || $urandom_range(99, 0) < p_req)) begin
            d_req   = 1'b1;
            d_we    = dir_d ? dir_d_we : 1'($urandom_range(1, 0));
            d_addr  = dir_d ? dir_d_addr : rand_addr();
            d_wdata = dir_d ? dir_d_data : rand_blk();
            d_wait  = 1; dir_d = 0;
        end
    endtask

    // Sample outputs mid-cycle, compare with the model, then advance the model.
    task automatic observe();
        bit strobe, busy_e, rd_e, wr_e, ir_e, dr_e;
        strobe = mem_read || mem_write;
        if (strobe && !prev_strobe) edges++;
        prev_strobe = strobe;
        if (strobe && !mr_pend) begin
            mr_pend = 1; mr_at = cyc + next_lat; mr_we = mem_write;
            mr_addr = mem_addr; mr_wdata = mem_wdata;
        end

        busy_e = act && cyc > g_cyc && cyc <= g_cyc + m_lat + 2;
        rd_e   = act && !m_we && cyc > g_cyc && cyc <= g_cyc + m_lat;
        wr_e   = act &&  m_we && cyc > g_cyc && cyc <= g_cyc + m_lat;
        ir_e   = act && !m_d && cyc == g_cyc + m_lat + 3;
        dr_e   = act &&  m_d && cyc == g_cyc + m_lat + 3;
        if (act && !m_we && cyc == g_cyc + m_lat + 2) begin
            if (m_d) exp_d_rd = ref_mem.exists(m_addr) ? ref_mem[m_addr] : line_init(m_addr);
            else     exp_i_rd = ref_mem.exists(m_addr) ? ref_mem[m_addr] : line_init(m_addr);
        end

        chk("busy",      BLK_W'(busy),      BLK_W'(busy_e));
        chk("mem_read",  BLK_W'(mem_read),  BLK_W'(rd_e));
        chk("mem_write", BLK_W'(mem_write), BLK_W'(wr_e));
        chk("i_ready",   BLK_W'(i_ready),   BLK_W'(ir_e));
        chk("d_ready",   BLK_W'(d_ready),   BLK_W'(dr_e));
        chk("i_rdata",   i_rdata,           exp_i_rd);
        chk("d_rdata",   d_rdata,           exp_d_rd);
        if (rd_e || wr_e) chk("mem_addr", BLK_W'(mem_addr), BLK_W'(m_addr));
        if (wr_e)         chk("mem_wdata", mem_wdata, m_wdata);
        if (i_ready) order_q.push_back(1'b0);
        if (d_ready) order_q.push_back(1'b1);

        if (ir_e || dr_e) begin
            chk("strobe_edges", BLK_W'(edges), BLK_W'(1));
            if (m_we) ref_mem[m_addr] = m_wdata;
            if (ir_e) i_done = 1; else d_done = 1;
            act = 0;
            free_cyc = cyc + 1;
        end

        if (rst_n && !act && cyc >= free_cyc && (i_req || d_req)) begin
            if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                m_d = !lg_d;
`else
                m_d = 1'b1;
`endif
            end else begin
                m_d = d_req;
            end
            lg_d     = m_d;
            m_we     = m_d && d_we;
            m_addr   = m_d ? d_addr : i_addr;
            m_wdata  = d_wdata;
            m_lat    = $urandom_range(lat_max, lat_min);
            next_lat = m_lat;
            g_cyc    = cyc;
            edges    = 0;
            act      = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        drive();
        @(negedge clk);
        observe();
    endtask

    task automatic apply_reset(input int hold);
        rst_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        i_wait = 0; d_wait = 0; i_done = 0; d_done = 0; dir_i = 0; dir_d = 0;
        mr_pend = 0; prev_strobe = 0; act = 0; lg_d = 0;
        exp_i_rd = '0; exp_d_rd = '0;
        p_req = 0; p_drop = 0; p_spur = 0;
        #1;
        chk("rst_busy",  BLK_W'(busy),      BLK_W'(0));
        chk("rst_read",  BLK_W'(mem_read),  BLK_W'(0));
        chk("rst_write", BLK_W'(mem_write), BLK_W'(0));
        chk("rst_irdy",  BLK_W'(i_ready),   BLK_W'(0));
        chk("rst_drdy",  BLK_W'(d_ready),   BLK_W'(0));
        for (int k = 0; k < hold; k++) step();
        rst_n = 1'b1;
        free_cyc = cyc + 1;
    endtask

    task automatic drain();
        int n;
        p_req = 0; p_drop = 0;
        n = 0;
        while ((act || i_wait || d_wait || dir_i || dir_d) && n < 300) begin
            step();
            n++;
        end
        if (act || i_wait || d_wait) chk("drain_timeout", BLK_W'(1), BLK_W'(0));
    endtask

    initial begin
        logic [BLK_W-1:0] wblk;
        int n;
        bit exp_ord [6];
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        lat_min = 1; lat_max = 1;
        apply_reset(3);

        // Single I read, latency 1.
        dir_i_addr = 32'h0001_0000; dir_i = 1;
        drain();
        chk("i_read_data", i_rdata, line_init(32'h0001_0000));

        // D write, then read it back.
        wblk = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_DEAD_BEEF;
        dir_d_we = 1; dir_d_addr = 32'h0001_0010; dir_d_data = wblk; dir_d = 1;
        drain();
        chk("d_write_keeps_rdata", d_rdata, BLK_W'(0));
        dir_d_we = 0; dir_d_addr = 32'h0001_0010; dir_d_data = '0; dir_d = 1;
        drain();
        chk("d_readback", d_rdata, wblk);

        // Both sides held continuously from reset.
        apply_reset(2);
        order_q.delete();
        lat_min = 1; lat_max = 1; p_req = 100;
        for (int k = 0; k < 40; k++) step();
        drain();
`ifdef ARB_ROUND_ROBIN_EN
        exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        chk("order_count", BLK_W'(order_q.size() >= 6), BLK_W'(1));
        for (int k = 0; k < 6 && k < order_q.size(); k++)
            chk($sformatf("order[%0d]", k), BLK_W'(order_q[k]), BLK_W'(exp_ord[k]));

        // Random traffic with drops and stray mem_ready.
        lat_min = 1; lat_max = 4; p_req = 35; p_drop = 10; p_spur = 8;
        for (int k = 0; k < 1500; k++) step();

        // Reset in the first BUSY cycle of a transaction.
        n = 0;
        while (!(act && cyc == g_cyc + 1) && n < 300) begin
            step();
            n++;
        end
        chk("mid_reset_found", BLK_W'(act && cyc == g_cyc + 1), BLK_W'(1));
        apply_reset(3);

        // Normal service after release.
        lat_min = 1; lat_max = 4; p_req = 35; p_drop = 10; p_spur = 8;
        for (int k = 0; k < 500; k++) step();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
